// File: rtl/bcd2binary_seq.sv
// Sequential three-digit BCD to 8-bit binary converter using reverse double-dabble.
// Fixed 8-cycle latency; out-of-range digits or values are reported on err with bin forced to 0.
module bcd2binary_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [7:0] bin,
  output logic       valid,
  output logic       err,
  output logic       busy
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [9:0] bcd_q, bcd_d;
  logic [7:0] bin_q, bin_d;
  logic       bad_q, bad_d;
  logic [7:0] res_q, res_d;
  logic       err_q, err_d;
  logic       valid_q, valid_d;

  logic [9:0] bcd_sh;
  logic [7:0] bin_sh;
  logic [9:0] bcd_fix;
  logic       ovf;
  logic       fail;

  // One reverse double-dabble step: shift the pair right, then pull each BCD nibble back by 3
  // when the shift left it at 8 or more. The 2-bit hundreds field needs no correction.
  always_comb begin
    bcd_sh  = {1'b0, bcd_q[9:1]};
    bin_sh  = {bcd_q[0], bin_q[7:1]};
    bcd_fix = bcd_sh;
    if (bcd_sh[7:4] >= 4'd8) begin
      bcd_fix[7:4] = bcd_sh[7:4] - 4'd3;
    end
    if (bcd_sh[3:0] >= 4'd8) begin
      bcd_fix[3:0] = bcd_sh[3:0] - 4'd3;
    end
    ovf  = (bcd_fix != 10'd0);
    fail = bad_q | ovf;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    bad_d   = bad_q;
    res_d   = res_q;
    err_d   = err_q;
    valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          bcd_d   = {hundreds, tens, ones};
          bin_d   = 8'h00;
          cnt_d   = 3'd0;
          bad_d   = (tens > 4'd9) | (ones > 4'd9);
          state_d = StShift;
        end
      end
      StShift: begin
        bcd_d = bcd_fix;
        bin_d = bin_sh;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          err_d   = fail;
          res_d   = fail ? 8'h00 : bin_sh;
          valid_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      bcd_q   <= 10'd0;
      bin_q   <= 8'h00;
      bad_q   <= 1'b0;
      res_q   <= 8'h00;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      bad_q   <= bad_d;
      res_q   <= res_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  assign bin   = res_q;
  assign err   = err_q;
  assign valid = valid_q;
  assign busy  = (state_q == StShift);

endmodule

// File: tb/tb_bcd2binary_seq.sv
// Directed self-checking bench for bcd2binary_seq: reset, conversions, error flags,
// exhaustive round trip, busy-time start, back-to-back accept and mid-conversion reset.
module tb_bcd2binary_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [7:0] bin;
  logic       valid;
  logic       err;
  logic       busy;

  int checks;
  int failures;

  bcd2binary_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones),
    .bin      (bin),
    .valid    (valid),
    .err      (err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one conversion and watch it to completion. lat is the number of edges after the
  // accepting edge at which valid was seen (20 means it never came).
  task automatic do_conv(input logic [1:0] h, input logic [3:0] t, input logic [3:0] o,
                         output logic [7:0] b, output logic e, output int lat,
                         output int busy_cyc, output logic overlap);
    @(negedge clk);
    hundreds = h;
    tens     = t;
    ones     = o;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    lat      = 0;
    busy_cyc = 0;
    overlap  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy && valid) overlap = 1'b1;
      if (valid) break;
      if (busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
    b = bin;
    e = err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    hundreds = 2'd0;
    tens = 4'd0;
    ones = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b want=0", busy);
    end
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b want=0", valid);
    end
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL reset_err got=%b want=0", err);
    end
    checks++;
    if (bin !== 8'h00) begin
      failures++;
      $display("FAIL reset_bin got=%h want=00", bin);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero();
    logic [7:0] b;
    logic       e;
    logic       ov;
    int         lat;
    int         bc;
    do_conv(2'd0, 4'd0, 4'd0, b, e, lat, bc, ov);
    checks++;
    if (lat !== 8) begin
      failures++;
      $display("FAIL zero_latency got=%0d want=8", lat);
    end
    checks++;
    if (bc !== 8) begin
      failures++;
      $display("FAIL zero_busy_cycles got=%0d want=8", bc);
    end
    checks++;
    if (ov !== 1'b0) begin
      failures++;
      $display("FAIL zero_busy_valid_overlap got=%b want=0", ov);
    end
    checks++;
    if (b !== 8'h00 || e !== 1'b0) begin
      failures++;
      $display("FAIL zero_result got bin=%h err=%b want bin=00 err=0", b, e);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_valid_drop got=%b want=0", valid);
    end
  endtask

  task automatic test_directed();
    logic [1:0] vh [8] = '{2'd2, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1};
    logic [3:0] vt [8] = '{4'd5, 4'd3, 4'd5, 4'd0, 4'd10, 4'd0, 4'd9, 4'd0};
    logic [3:0] vo [8] = '{4'd5, 4'd7, 4'd6, 4'd0, 4'd0, 4'd15, 4'd9, 4'd0};
    logic [7:0] vb [8] = '{8'hFF, 8'h89, 8'h00, 8'h00, 8'h00, 8'h00, 8'h63, 8'h64};
    logic       ve [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] b;
    logic       e;
    logic       ov;
    int         lat;
    int         bc;
    for (int i = 0; i < 8; i++) begin
      do_conv(vh[i], vt[i], vo[i], b, e, lat, bc, ov);
      checks++;
      if (lat !== 8 || b !== vb[i] || e !== ve[i]) begin
        failures++;
        $display("FAIL directed_%0d in=%0d,%0d,%0d got lat=%0d bin=%h err=%b want lat=8 bin=%h err=%b",
                 i, vh[i], vt[i], vo[i], lat, b, e, vb[i], ve[i]);
      end
    end
  endtask

  task automatic test_round_trip();
    logic [7:0] b;
    logic       e;
    logic       ov;
    int         lat;
    int         bc;
    int         bad;
    bad = 0;
    for (int v = 0; v < 256; v++) begin
      do_conv(2'(v / 100), 4'((v / 10) % 10), 4'(v % 10), b, e, lat, bc, ov);
      checks++;
      if (b !== 8'(v) || e !== 1'b0 || lat !== 8) begin
        failures++;
        bad++;
        if (bad <= 5)
          $display("FAIL round_trip v=%0d got bin=%0d err=%b lat=%0d want bin=%0d err=0 lat=8",
                   v, b, e, lat, v);
      end
    end
  endtask

  // Start pulsed while busy (with new digits) must be ignored; then a start accepted at k+9
  // while valid is high must produce the next valid at k+17.
  task automatic test_back_to_back();
    int         nvalid;
    int         first_lat;
    int         second_lat;
    logic [7:0] b1;
    logic [7:0] b2;
    @(negedge clk);
    hundreds = 2'd1;
    tens     = 4'd3;
    ones     = 4'd7;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start      = 1'b0;
    nvalid     = 0;
    first_lat  = -1;
    second_lat = -1;
    b1 = 8'hxx;
    b2 = 8'hxx;
    for (int lat = 0; lat < 24; lat++) begin
      if (valid) begin
        nvalid++;
        if (first_lat < 0) begin
          first_lat = lat;
          b1 = bin;
        end else if (second_lat < 0) begin
          second_lat = lat;
          b2 = bin;
        end
      end
      start = 1'b0;
      if (lat == 2) begin
        hundreds = 2'd0;
        tens     = 4'd4;
        ones     = 4'd2;
        start    = 1'b1;
      end
      if (lat == 8) begin
        hundreds = 2'd0;
        tens     = 4'd9;
        ones     = 4'd9;
        start    = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (first_lat !== 8 || b1 !== 8'h89) begin
      failures++;
      $display("FAIL busy_start_ignored got lat=%0d bin=%h want lat=8 bin=89", first_lat, b1);
    end
    checks++;
    if (second_lat !== 17 || b2 !== 8'h63) begin
      failures++;
      $display("FAIL back_to_back got lat=%0d bin=%h want lat=17 bin=63", second_lat, b2);
    end
    checks++;
    if (nvalid !== 2) begin
      failures++;
      $display("FAIL back_to_back_count got=%0d want=2", nvalid);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    logic       e;
    logic       ov;
    int         lat;
    int         bc;
    int         nvalid;
    logic       st_ok;
    do_conv(2'd2, 4'd5, 4'd5, b, e, lat, bc, ov);
    @(negedge clk);
    hundreds = 2'd1;
    tens     = 4'd3;
    ones     = 4'd7;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    nvalid = 0;
    st_ok  = 1'b1;
    for (int l = 0; l < 16; l++) begin
      if (valid) nvalid++;
      if (l == 4 && (busy !== 1'b0 || valid !== 1'b0 || err !== 1'b0 || bin !== 8'h00))
        st_ok = 1'b0;
      if (l == 3) rst_n = 1'b0;
      if (l == 5) rst_n = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (st_ok !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_outputs got non-reset outputs after abort");
    end
    checks++;
    if (nvalid !== 0) begin
      failures++;
      $display("FAIL reset_mid_no_valid got=%0d want=0", nvalid);
    end
    checks++;
    if (busy !== 1'b0 || bin !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_idle got busy=%b bin=%h want busy=0 bin=00", busy, bin);
    end
    do_conv(2'd0, 4'd4, 4'd2, b, e, lat, bc, ov);
    checks++;
    if (lat !== 8 || b !== 8'h2A || e !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_recover got lat=%0d bin=%h err=%b want lat=8 bin=2a err=0",
               lat, b, e);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_zero();
    test_directed();
    test_round_trip();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
